// File: rtl/rpn_stack_ctrl.sv
// RPN evaluation controller: turns operand/operator tokens into push/pop strobes
// for the downstream LIFO and computes ADD/SUB/MUL/EQ on the popped entries.
module rpn_stack_ctrl #(
  parameter int W = 16,
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_is_op,
  input  logic [W-1:0] tok_data,
  output logic         stk_push,
  output logic         stk_pop,
  output logic [W-1:0] stk_datain,
  input  logic [W-1:0] stk_dataout,
  input  logic         stk_full,
  input  logic         stk_empty,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam int DW = $clog2(N + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(N);
  localparam logic [DW-1:0] DEPTH_TWO = DW'(2);

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP_B,
    CAP_B,
    POP_A,
    CAP_A,
    PUSH_R
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [DW-1:0]  depth;
  logic [W-1:0]   tok_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   alu_out;
  logic           is_eq;
  logic           overflow;
  logic           underflow;
  logic           tok_err;
  logic           op_is_eq;

  // Acceptance-time checks use the live token and the mirrored depth
  assign is_eq     = (tok_data[1:0] == 2'd3);
  assign overflow  = !tok_is_op && ((depth == DEPTH_MAX) || stk_full);
  assign underflow = tok_is_op && (is_eq ? ((depth == '0) || stk_empty)
                                         : (depth < DEPTH_TWO));
  assign tok_err   = overflow || underflow;
  assign op_is_eq  = (tok_q[1:0] == 2'd3);

  always_comb begin
    alu_out = '0;
    case (tok_q[1:0])
      2'd0:    alu_out = a_q + b_q;
      2'd1:    alu_out = a_q - b_q;
      2'd2:    alu_out = a_q * b_q;
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    tok_ready  = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_datain = '0;
    case (state)
      IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid && !tok_err) state_nx = tok_is_op ? POP_B : PUSH;
      end
      PUSH: begin
        stk_push   = 1'b1;
        stk_datain = tok_q;
        state_nx   = IDLE;
      end
      POP_B: begin
        stk_pop  = 1'b1;
        state_nx = CAP_B;
      end
      CAP_B:   state_nx = op_is_eq ? IDLE : POP_A;
      POP_A: begin
        stk_pop  = 1'b1;
        state_nx = CAP_A;
      end
      CAP_A:   state_nx = PUSH_R;
      PUSH_R: begin
        stk_push   = 1'b1;
        stk_datain = alu_out;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Popped data is registered by the stack, so it is captured one cycle after each pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth        <= '0;
      tok_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (state == IDLE && tok_valid && !tok_err) tok_q <= tok_data;
      case (state)
        PUSH:   depth <= depth + DW'(1);
        CAP_B: begin
          b_q   <= stk_dataout;
          depth <= depth - DW'(1);
          if (op_is_eq) begin
            result       <= stk_dataout;
            result_valid <= 1'b1;
          end
        end
        CAP_A: begin
          a_q   <= stk_dataout;
          depth <= depth - DW'(1);
        end
        PUSH_R: depth <= depth + DW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err      <= 1'b0;
      err_code <= 2'b00;
    end else if (state == IDLE && tok_valid && tok_err) begin
      err      <= 1'b1;
      err_code <= overflow ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: attaches a behavioural LIFO and compares every cycle
// against a token-level RPN model, plus directed hand-computed result checks.
module tb_rpn_stack_ctrl;

  localparam int W = 16;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic         tok_is_op = 1'b0;
  logic [W-1:0] tok_data = '0;
  logic         stk_push;
  logic         stk_pop;
  logic [W-1:0] stk_datain;
  logic [W-1:0] stk_dataout;
  logic         stk_full;
  logic         stk_empty;
  logic [W-1:0] result;
  logic         result_valid;
  logic         err;
  logic [1:0]   err_code;

  rpn_stack_ctrl #(.W(W), .N(N)) dut (
    .clk(clk), .reset(reset),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_datain(stk_datain), .stk_dataout(stk_dataout),
    .stk_full(stk_full), .stk_empty(stk_empty),
    .result(result), .result_valid(result_valid), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Behavioural LIFO with registered pop data, sharing the controller's reset
  logic [W-1:0] stkMem [N];
  int stkCnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      stkCnt      <= 0;
      stk_dataout <= '0;
    end else if (stk_push && stkCnt < N) begin
      stkMem[stkCnt] <= stk_datain;
      stkCnt         <= stkCnt + 1;
    end else if (stk_pop && stkCnt > 0) begin
      stk_dataout <= stkMem[stkCnt-1];
      stkCnt      <= stkCnt - 1;
    end
  end
  assign stk_full  = (stkCnt == N);
  assign stk_empty = (stkCnt == 0);

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, expv);
    end
  endtask

  // Token-level model: each accepted token expands into its expected cycle schedule
  typedef struct {
    logic         push;
    logic         pop;
    logic [W-1:0] din;
    logic         ready;
    logic         rv;
    logic [W-1:0] res;
  } exp_t;

  exp_t         sched[$];
  logic [W-1:0] mStack[$];
  logic [W-1:0] expResult = '0;
  logic         expErr = 1'b0;
  logic [1:0]   expCode = 2'b00;
  logic         errPend = 1'b0;
  logic [1:0]   pendCode = 2'b00;

  function automatic exp_t mk(logic pu, logic po, logic [W-1:0] d, logic rdy, logic v, logic [W-1:0] r);
    exp_t e;
    e.push = pu; e.pop = po; e.din = d; e.ready = rdy; e.rv = v; e.res = r;
    return e;
  endfunction

  task automatic modelAccept(input logic isOp, input logic [W-1:0] data);
    logic [W-1:0]   a, b, r;
    logic [2*W-1:0] prod;
    if (!isOp) begin
      if (mStack.size() == N) begin
        errPend = 1'b1; pendCode = 2'b10;
      end else begin
        mStack.push_back(data);
        sched.push_back(mk(1'b1, 1'b0, data, 1'b0, 1'b0, '0));
      end
    end else if (data[1:0] == 2'd3) begin
      if (mStack.size() == 0) begin
        errPend = 1'b1; pendCode = 2'b01;
      end else begin
        b = mStack.pop_back();
        sched.push_back(mk(1'b0, 1'b1, '0, 1'b0, 1'b0, '0));
        sched.push_back(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, '0));
        sched.push_back(mk(1'b0, 1'b0, '0, 1'b1, 1'b1, b));
      end
    end else begin
      if (mStack.size() < 2) begin
        errPend = 1'b1; pendCode = 2'b01;
      end else begin
        b = mStack.pop_back();
        a = mStack.pop_back();
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (data[1:0])
          2'd0:    r = a + b;
          2'd1:    r = a - b;
          default: r = prod[W-1:0];
        endcase
        mStack.push_back(r);
        sched.push_back(mk(1'b0, 1'b1, '0, 1'b0, 1'b0, '0));
        sched.push_back(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, '0));
        sched.push_back(mk(1'b0, 1'b1, '0, 1'b0, 1'b0, '0));
        sched.push_back(mk(1'b0, 1'b0, '0, 1'b0, 1'b0, '0));
        sched.push_back(mk(1'b1, 1'b0, r, 1'b0, 1'b0, '0));
      end
    end
  endtask

  // Per-cycle comparison, sampled mid-cycle away from the active edge
  always @(negedge clk) begin
    exp_t cur;
    if (!reset) begin
      sched.delete();
      mStack.delete();
      expResult = '0; expErr = 1'b0; expCode = 2'b00; errPend = 1'b0;
      checkOutput("rst push", 32'(stk_push), 32'd0);
      checkOutput("rst pop", 32'(stk_pop), 32'd0);
      checkOutput("rst datain", 32'(stk_datain), 32'd0);
      checkOutput("rst result", 32'(result), 32'd0);
      checkOutput("rst rvalid", 32'(result_valid), 32'd0);
      checkOutput("rst err", 32'(err), 32'd0);
      checkOutput("rst errcode", 32'(err_code), 32'd0);
    end else begin
      if (sched.size() > 0) cur = sched.pop_front();
      else                  cur = mk(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
      if (cur.rv) expResult = cur.res;
      if (errPend) begin
        expErr = 1'b1; expCode = pendCode; errPend = 1'b0;
      end
      checkOutput("push", 32'(stk_push), 32'(cur.push));
      checkOutput("pop", 32'(stk_pop), 32'(cur.pop));
      checkOutput("datain", 32'(stk_datain), 32'(cur.din));
      checkOutput("ready", 32'(tok_ready), 32'(cur.ready));
      checkOutput("rvalid", 32'(result_valid), 32'(cur.rv));
      checkOutput("result", 32'(result), 32'(expResult));
      checkOutput("err", 32'(err), 32'(expErr));
      checkOutput("errcode", 32'(err_code), 32'(expCode));
      if (tok_valid && cur.ready) modelAccept(tok_is_op, tok_data);
    end
  end

  logic [W-1:0] pushLog[$];
  int popCount = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (stk_push) pushLog.push_back(stk_datain);
      if (stk_pop) popCount++;
    end
  end

  int accCyc = 0;

  // Offers a token from just after a rising edge and holds it until accepted
  task automatic applyStimulus(input logic isOp, input logic [W-1:0] data);
    int waitCyc = 0;
    tok_valid = 1'b1; tok_is_op = isOp; tok_data = data;
    forever begin
      @(negedge clk);
      if (tok_ready) begin
        accCyc = cyc;
        break;
      end
      waitCyc++;
      if (waitCyc > 20) begin
        total++; bad++;
        $display("[TB] FAIL accept timeout @cyc %0d: got ready=0 want ready=1", cyc);
        break;
      end
    end
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  task automatic waitResult(input string nm, input logic [W-1:0] expv);
    bit found = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (result_valid) begin
        checkOutput(nm, 32'(result), 32'(expv));
        found = 1;
        break;
      end
    end
    if (!found) begin
      total++; bad++;
      $display("[TB] FAIL %s timeout: got no result_valid want %h", nm, expv);
    end
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    tok_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  int a0, a1, a2, a3;

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("post-rst ready", 32'(tok_ready), 32'd1);
    checkOutput("post-rst result", 32'(result), 32'd0);
    checkOutput("post-rst err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Reset while an operand push is in flight
    applyStimulus(1'b0, 16'h0005);
    reset = 1'b0;
    #1;
    checkOutput("mid-rst push", 32'(stk_push), 32'd0);
    checkOutput("mid-rst datain", 32'(stk_datain), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid-rst empty", 32'(stk_empty), 32'd1);

    // 5 3 - =
    pushLog.delete();
    applyStimulus(1'b0, 16'h0005); a0 = accCyc;
    applyStimulus(1'b0, 16'h0003); a1 = accCyc;
    applyStimulus(1'b1, 16'h0001); a2 = accCyc;
    applyStimulus(1'b1, 16'h0003); a3 = accCyc;
    waitResult("sub result", 16'h0002);
    checkOutput("operand spacing", 32'(a1 - a0), 32'd2);
    checkOutput("operator spacing", 32'(a3 - a2), 32'd6);
    checkOutput("push count", 32'(pushLog.size()), 32'd3);
    if (pushLog.size() == 3) begin
      checkOutput("push0", 32'(pushLog[0]), 32'h5);
      checkOutput("push1", 32'(pushLog[1]), 32'h3);
      checkOutput("push2", 32'(pushLog[2]), 32'h2);
    end
    checkOutput("sub empty", 32'(stk_empty), 32'd1);

    // Modulo wrap on ADD and MUL
    applyStimulus(1'b0, 16'hFFFF);
    applyStimulus(1'b0, 16'h0002);
    applyStimulus(1'b1, 16'h0000);
    applyStimulus(1'b1, 16'h0003);
    waitResult("add wrap", 16'h0001);
    applyStimulus(1'b0, 16'h0100);
    applyStimulus(1'b0, 16'h0100);
    applyStimulus(1'b1, 16'h0002);
    applyStimulus(1'b1, 16'h0003);
    waitResult("mul wrap", 16'h0000);

    // Overflow on the fourth operand
    pushLog.delete();
    applyStimulus(1'b0, 16'h0001);
    applyStimulus(1'b0, 16'h0002);
    applyStimulus(1'b0, 16'h0003);
    applyStimulus(1'b0, 16'h0004);
    checkOutput("ovf err", 32'(err), 32'd1);
    checkOutput("ovf code", 32'(err_code), 32'd2);
    checkOutput("ovf ready", 32'(tok_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ovf pushes", 32'(pushLog.size()), 32'd3);
    applyStimulus(1'b1, 16'h0003);
    waitResult("ovf eq", 16'h0003);

    // Underflow
    doReset();
    popCount = 0;
    applyStimulus(1'b1, 16'h0000);
    checkOutput("und err", 32'(err), 32'd1);
    checkOutput("und code", 32'(err_code), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("und pops", 32'(popCount), 32'd0);
    applyStimulus(1'b0, 16'h0007);
    applyStimulus(1'b1, 16'h0000);
    checkOutput("und code2", 32'(err_code), 32'd1);
    applyStimulus(1'b1, 16'h0003);
    waitResult("und eq", 16'h0007);
    checkOutput("und sticky", 32'(err), 32'd1);

    // Reset landing in POP_A of an ADD
    doReset();
    applyStimulus(1'b0, 16'h0001);
    applyStimulus(1'b0, 16'h0002);
    applyStimulus(1'b1, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("popA strobe", 32'(stk_pop), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("popA drop", 32'(stk_pop), 32'd0);
    checkOutput("popA result", 32'(result), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 16'h0009);
    applyStimulus(1'b1, 16'h0003);
    waitResult("post-rst eq", 16'h0009);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
